// File: rtl/abba_feeder_if.sv
// Producer/recognizer-side signal bundle for abba_feeder.
// The feeder uses the slave modport and the environment drives the master modport.
interface abba_feeder_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [7:0]    in_char;
    logic          in_valid;
    logic          in_ready;
    logic          run;
    logic [1:2]    x;
    logic          x_valid;
    logic [CW-1:0] count;

    modport master (
        output in_char, in_valid, run,
        input  in_ready, x, x_valid, count
    );

    modport slave (
        input  in_char, in_valid, run,
        output in_ready, x, x_valid, count
    );
endinterface

// File: rtl/abba_feeder.sv
// Encodes ASCII characters into 2-bit symbols, buffers them and streams one per clock
// to the abba recognizer. Define ABBA_FEEDER_CASE_FOLD_EN to also map 'A'/'B'.
module abba_feeder #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [1:0]  IDLE_SYM = 2'b11
) (
    input logic          clock,
    input logic          reset,
    abba_feeder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:2]    x_q, x_d;
    logic          x_valid_q, x_valid_d;
    logic          in_ready;
    logic          push;
    logic          pop;

    function automatic logic [1:0] encode(input logic [7:0] c);
        logic [1:0] s;
        s = 2'b10;
        case (c)
            8'h61:   s = 2'b00;
            8'h62:   s = 2'b01;
`ifdef ABBA_FEEDER_CASE_FOLD_EN
            8'h41:   s = 2'b00;
            8'h42:   s = 2'b01;
`endif
            default: s = 2'b10;
        endcase
        return s;
    endfunction

    always_comb begin
        // No full-bypass: a simultaneous pop does not open the door when full.
        in_ready  = (count_q < CW'(DEPTH)) && !reset;
        push      = bus.in_valid && in_ready;
        pop       = bus.run && (count_q != '0);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        x_d       = IDLE_SYM;
        x_valid_d = 1'b0;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            x_d       = mem_q[rd_ptr_q];
            x_valid_d = 1'b1;
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            x_q       <= IDLE_SYM;
            x_valid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
        end
    end

    // Storage is not cleared on reset; push is already blocked while reset is high.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= encode(bus.in_char);
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.x        = x_q;
    assign bus.x_valid  = x_valid_q;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_abba_feeder.sv
// Directed bench for abba_feeder: streaming, full/refuse, wrap, reset and case-fold mapping.
module tb_abba_feeder;
    localparam int unsigned DEPTH = 4;

    logic clock;
    logic reset;
    int   nvec;
    int   nerr;

    abba_feeder_if #(.DEPTH(DEPTH)) bus ();

    abba_feeder #(.DEPTH(DEPTH), .IDLE_SYM(2'b11)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        bus.run      = 1'b0;
        step();
        step();
        nvec++; if (bus.count !== 3'd0) begin nerr++; $display("FAIL rst_count got %0d want 0", bus.count); end
        nvec++; if (bus.x !== 2'b11) begin nerr++; $display("FAIL rst_x got %b want 11", bus.x); end
        nvec++; if (bus.x_valid !== 1'b0) begin nerr++; $display("FAIL rst_xv got %b want 0", bus.x_valid); end
        nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready got %b want 0", bus.in_ready); end
        reset = 1'b0;
        #1;
        nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready_after got %b want 1", bus.in_ready); end
    endtask

    task automatic test_stream();
        logic [7:0] s [4];
        logic [1:0] e [4];
        s[0] = 8'h61; s[1] = 8'h62; s[2] = 8'h62; s[3] = 8'h61;
        e[0] = 2'b00; e[1] = 2'b01; e[2] = 2'b01; e[3] = 2'b00;
        bus.run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                bus.in_valid = 1'b1;
                bus.in_char  = s[i];
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            if (i == 0) begin
                nvec++; if (bus.x_valid !== 1'b0) begin nerr++; $display("FAIL stream_nobypass xv got %b want 0", bus.x_valid); end
            end else begin
                nvec++; if (bus.x !== e[i-1] || bus.x_valid !== 1'b1) begin
                    nerr++; $display("FAIL stream_x[%0d] got %b/%b want %b/1", i - 1, bus.x, bus.x_valid, e[i-1]);
                end
            end
        end
        step();
        nvec++; if (bus.x !== 2'b11 || bus.x_valid !== 1'b0) begin nerr++; $display("FAIL stream_idle got %b/%b want 11/0", bus.x, bus.x_valid); end
        nvec++; if (bus.count !== 3'd0) begin nerr++; $display("FAIL stream_count got %0d want 0", bus.count); end
    endtask

    task automatic test_full_refuse();
        logic [7:0] s [5];
        logic [1:0] e [5];
        s[0] = 8'h61; s[1] = 8'h62; s[2] = 8'h63; s[3] = 8'h64; s[4] = 8'h65;
        e[0] = 2'b00; e[1] = 2'b01; e[2] = 2'b10; e[3] = 2'b10; e[4] = 2'b11;
        bus.run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_char  = s[i];
            #1;
            nvec++; if (bus.in_ready !== (i < 4)) begin nerr++; $display("FAIL full_ready[%0d] got %b want %b", i, bus.in_ready, (i < 4)); end
            step();
        end
        bus.in_valid = 1'b0;
        nvec++; if (bus.count !== 3'd4) begin nerr++; $display("FAIL full_count got %0d want 4", bus.count); end
        nvec++; if (bus.x_valid !== 1'b0 || bus.x !== 2'b11) begin nerr++; $display("FAIL full_paused got %b/%b want 11/0", bus.x, bus.x_valid); end
        bus.run = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            nvec++; if (bus.x !== e[j] || bus.x_valid !== (j < 4)) begin
                nerr++; $display("FAIL full_drain[%0d] got %b/%b want %b/%b", j, bus.x, bus.x_valid, e[j], (j < 4));
            end
        end
    endtask

    task automatic test_full_hold();
        logic [1:0] e [5];
        e[0] = 2'b00; e[1] = 2'b01; e[2] = 2'b10; e[3] = 2'b10; e[4] = 2'b11;
        bus.run      = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_char = (i % 2 == 0) ? 8'h61 : 8'h62;
            step();
        end
        bus.in_char = 8'h63;
        nvec++; if (bus.in_ready !== 1'b0 || bus.count !== 3'd4) begin nerr++; $display("FAIL hold_full got rdy=%b cnt=%0d want 0/4", bus.in_ready, bus.count); end
        for (int k = 0; k < 2; k++) begin
            bus.run = 1'b1;
            step();
            nvec++; if (bus.count !== 3'd3 || bus.in_ready !== 1'b1) begin
                nerr++; $display("FAIL hold_pop[%0d] got cnt=%0d rdy=%b want 3/1", k, bus.count, bus.in_ready);
            end
            bus.run = 1'b0;
            step();
            nvec++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
                nerr++; $display("FAIL hold_refill[%0d] got cnt=%0d rdy=%b want 4/0", k, bus.count, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        bus.run      = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            nvec++; if (bus.x !== e[j] || bus.x_valid !== (j < 4)) begin
                nerr++; $display("FAIL hold_drain[%0d] got %b/%b want %b/%b", j, bus.x, bus.x_valid, e[j], (j < 4));
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] s [6];
        logic       r [6];
        logic [1:0] e [6];
        int         k;
        s[0] = 8'h61; s[1] = 8'h62; s[2] = 8'h7a; s[3] = 8'h62; s[4] = 8'h61; s[5] = 8'h62;
        r[0] = 1'b0;  r[1] = 1'b1;  r[2] = 1'b0;  r[3] = 1'b1;  r[4] = 1'b0;  r[5] = 1'b1;
        e[0] = 2'b00; e[1] = 2'b01; e[2] = 2'b10; e[3] = 2'b01; e[4] = 2'b00; e[5] = 2'b01;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 6) begin
                bus.in_valid = 1'b1;
                bus.in_char  = s[i];
                bus.run      = r[i];
            end else begin
                bus.in_valid = 1'b0;
                bus.run      = 1'b1;
            end
            step();
            if (bus.x_valid === 1'b1) begin
                nvec++;
                if (k >= 6) begin
                    nerr++; $display("FAIL wrap_extra got %b want none", bus.x);
                end else if (bus.x !== e[k]) begin
                    nerr++; $display("FAIL wrap_order[%0d] got %b want %b", k, bus.x, e[k]);
                end
                k++;
            end
        end
        nvec++; if (k != 6) begin nerr++; $display("FAIL wrap_total got %0d want 6", k); end
    endtask

    task automatic test_reset_mid();
        bus.run      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h61;
        for (int i = 0; i < 3; i++) step();
        bus.run = 1'b1;
        step();
        nvec++; if (bus.count !== 3'd3 || bus.x_valid !== 1'b1) begin nerr++; $display("FAIL rmid_pre got cnt=%0d xv=%b want 3/1", bus.count, bus.x_valid); end
        reset = 1'b1;
        #1;
        nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL rmid_ready_hi got %b want 0", bus.in_ready); end
        step();
        nvec++; if (bus.count !== 3'd0) begin nerr++; $display("FAIL rmid_count got %0d want 0", bus.count); end
        nvec++; if (bus.x !== 2'b11 || bus.x_valid !== 1'b0) begin nerr++; $display("FAIL rmid_x got %b/%b want 11/0", bus.x, bus.x_valid); end
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL rmid_ready_lo got %b want 1", bus.in_ready); end
        step();
        nvec++; if (bus.count !== 3'd0 || bus.x_valid !== 1'b0) begin nerr++; $display("FAIL rmid_empty got cnt=%0d xv=%b want 0/0", bus.count, bus.x_valid); end
    endtask

    task automatic test_case_fold();
        logic [1:0] ea;
        logic [1:0] eb;
`ifdef ABBA_FEEDER_CASE_FOLD_EN
        ea = 2'b00; eb = 2'b01;
`else
        ea = 2'b10; eb = 2'b10;
`endif
        bus.run      = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h41;
        step();
        bus.in_char = 8'h42;
        step();
        nvec++; if (bus.x !== ea || bus.x_valid !== 1'b1) begin nerr++; $display("FAIL fold_A got %b/%b want %b/1", bus.x, bus.x_valid, ea); end
        bus.in_valid = 1'b0;
        step();
        nvec++; if (bus.x !== eb || bus.x_valid !== 1'b1) begin nerr++; $display("FAIL fold_B got %b/%b want %b/1", bus.x, bus.x_valid, eb); end
        step();
        nvec++; if (bus.x_valid !== 1'b0) begin nerr++; $display("FAIL fold_idle got %b want 0", bus.x_valid); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_stream();
        test_full_refuse();
        test_full_hold();
        test_wrap();
        test_reset_mid();
        test_case_fold();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
